// File: rtl/stark_fpu_issue_arb_pkg.sv
// Stark_pkg: types and constants shared by the Stark FPU issue arbiter.
//
// Contents:
//   FPU_ARB_LAT     default pipelined-op latency (issue to result, clocks)
//   FPU_ARB_RW      ROB index width carried by a conveyor entry; RW must not exceed it
//   fpu_arb_state_t iterative-op sequencer states (IDLE, BUSY, WB)
//   fpu_inflight_t  one conveyor slot: valid, sticky kill, ROB index
package Stark_pkg;

  localparam int FPU_ARB_LAT = 2;
  localparam int FPU_ARB_RW  = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    WB   = 2'd2
  } fpu_arb_state_t;

  typedef struct packed {
    logic                  v;
    logic                  kill;
    logic [FPU_ARB_RW-1:0] rndx;
  } fpu_inflight_t;

endpackage

// File: rtl/stark_fpu_issue_arb_rr_arbiter.sv
// stark_rr_arbiter: NREQ-wide round-robin arbiter with an enable.
//
// Ports:
//   clk, rst  clock and synchronous active-high reset (pointer returns to 0)
//   en        when low nothing is granted and the pointer holds
//   req       request vector
//   gnt       one-hot grant (combinational)
//   win       index of the granted requester (valid when any=1)
//   any       a grant is given this cycle
module stark_rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   win,
  output logic            any
);

  logic [IW-1:0] ptr;
  logic [IW-1:0] cand;
  logic          found;

  // Scan from the pointer upwards (wrapping) and take the first request seen.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int off = 0; off < NREQ; off++) begin
      cand = IW'((int'(ptr) + off) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    any = found & en;
    gnt = '0;
    if (any) gnt[win] = 1'b1;
  end

  // The pointer only moves past a winner that was actually granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (any) begin
      ptr <= (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
    end
  end

endmodule

// File: rtl/stark_fpu_issue_arb.sv
// stark_fpu_issue_arb: issue arbiter and sequencer in front of the Stark meta-FPU.
//
// Picks one reservation-station requester per cycle, registers it onto the
// single FPU issue port, tracks pipelined ops in a LAT-deep conveyor and
// serialises iterative ops (div/sqrt) through an IDLE/BUSY/WB sequencer.
// Stomped ops still write back, but with wb_kill set.
//
// Build option: define STARK_FPU_FIXED_PRIO_EN for fixed priority (lowest
// index wins, no round-robin pointer); otherwise round-robin.
//
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   req, iter   per-requester ready / op-is-iterative
//   rndx        per-requester ROB index, slot i at [i*RW +: RW]
//   stomp       ROB kill mask, one bit per ROB index
//   gnt         one-hot combinational grant (requester dequeues on it)
//   fpu_issue   registered issue strobe; fpu_sel its requester index
//   fpu_idle    nothing in flight
//   fpu_done    iterative op finished (ignored unless BUSY)
//   wb_v, wb_rndx, wb_kill  writeback valid / ROB index / killed
module stark_fpu_issue_arb
  import Stark_pkg::*;
#(
  parameter  int NREQ = 4,
  parameter  int LAT  = FPU_ARB_LAT,
  parameter  int RW   = FPU_ARB_RW,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    iter,
  input  logic [NREQ*RW-1:0] rndx,
  input  logic [2**RW-1:0]   stomp,
  output logic [NREQ-1:0]    gnt,
  output logic               fpu_issue,
  output logic [IW-1:0]      fpu_sel,
  output logic               fpu_idle,
  input  logic               fpu_done,
  output logic               wb_v,
  output logic [RW-1:0]      wb_rndx,
  output logic               wb_kill
);

  fpu_arb_state_t state;

  logic [RW-1:0]   rndx_a [NREQ];
  logic [NREQ-1:0] elig;
  logic            pipe_empty;
  logic            grant;
  logic [IW-1:0]   win;

  logic            iss_v;
  logic            iss_iter;
  logic [RW-1:0]   iss_rndx;

  fpu_inflight_t   conv [LAT];
  fpu_inflight_t   conv_out;
  logic [LAT-1:0]  conv_v;

  logic [RW-1:0]   busy_rndx;
  logic            busy_kill;

  // Unpack the flattened ROB index bus and gather conveyor valids.
  always_comb begin
    for (int i = 0; i < NREQ; i++) rndx_a[i] = rndx[i*RW +: RW];
    for (int k = 0; k < LAT; k++) conv_v[k] = conv[k].v;
    pipe_empty = ~iss_v & ~(|conv_v);
    conv_out   = conv[LAT-1];
  end

  // Iterative ops may only enter an empty pipe so their writeback can never
  // collide with a pipelined result; a request stomped this cycle is skipped.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = req[i] & ~stomp[rndx_a[i]] & (state == IDLE) & (~iter[i] | pipe_empty);
    end
  end

`ifdef STARK_FPU_FIXED_PRIO_EN
  // Lowest eligible index wins.
  always_comb begin
    gnt   = '0;
    grant = 1'b0;
    win   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (elig[i]) begin
        grant = 1'b1;
        win   = IW'(i);
      end
    end
    if (grant) gnt[win] = 1'b1;
  end
`else
  stark_rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr (
    .clk  (clk),
    .rst  (rst),
    .en   (state == IDLE),
    .req  (elig),
    .gnt  (gnt),
    .win  (win),
    .any  (grant)
  );
`endif

  // Issue stage: fpu_sel keeps the last winner so the operand mux stays put.
  always_ff @(posedge clk) begin
    if (rst) begin
      iss_v    <= 1'b0;
      iss_iter <= 1'b0;
      iss_rndx <= '0;
      fpu_sel  <= '0;
    end else begin
      iss_v <= grant;
      if (grant) begin
        fpu_sel  <= win;
        iss_iter <= iter[win];
        iss_rndx <= rndx_a[win];
      end
    end
  end

  assign fpu_issue = iss_v;

  // Conveyor for pipelined ops. Kill bits are sticky: a stomp seen in any
  // in-flight cycle (issue stage included) follows the entry to writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LAT; k++) conv[k] <= '0;
    end else begin
      conv[0].v    <= iss_v & ~iss_iter;
      conv[0].kill <= stomp[iss_rndx];
      conv[0].rndx <= FPU_ARB_RW'(iss_rndx);
      for (int k = 1; k < LAT; k++) begin
        conv[k].v    <= conv[k-1].v;
        conv[k].kill <= conv[k-1].kill | stomp[conv[k-1].rndx[RW-1:0]];
        conv[k].rndx <= conv[k-1].rndx;
      end
    end
  end

  // Iterative sequencer. BUSY is entered on the grant edge so no pipelined op
  // can slip in behind the iterative one while it sits in the issue stage.
  // A stomp during BUSY only marks the result; the FPU runs to completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy_rndx <= '0;
      busy_kill <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant && iter[win]) begin
            state     <= BUSY;
            busy_rndx <= rndx_a[win];
            busy_kill <= 1'b0;
          end
        end
        BUSY: begin
          busy_kill <= busy_kill | stomp[busy_rndx];
          if (fpu_done) state <= WB;
        end
        WB:      state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Writeback mux; a stomp landing on the writeback cycle itself also kills.
  always_comb begin
    if (state == WB) begin
      wb_v    = 1'b1;
      wb_rndx = busy_rndx;
      wb_kill = busy_kill | stomp[busy_rndx];
    end else begin
      wb_v    = conv_out.v;
      wb_rndx = conv_out.rndx[RW-1:0];
      wb_kill = conv_out.v & (conv_out.kill | stomp[conv_out.rndx[RW-1:0]]);
    end
    fpu_idle = (state == IDLE) & pipe_empty;
  end

endmodule

// File: tb/tb_stark_fpu_issue_arb.sv
// Testbench for stark_fpu_issue_arb (NREQ=4, LAT=2, RW=6).
// Stimulus pushes expected writebacks into a queue; an independent monitor
// pops and compares whenever wb_v is seen. Grants and issue outputs are
// compared directly in the stimulus sequence.
module tb_stark_fpu_issue_arb;

  localparam int NREQ = 4;
  localparam int LAT  = 2;
  localparam int RW   = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req, iter, gnt;
  logic [23:0] rndx;
  logic [63:0] stomp;
  logic        fpu_issue;
  logic [1:0]  fpu_sel;
  logic        fpu_idle, fpu_done;
  logic        wb_v;
  logic [5:0]  wb_rndx;
  logic        wb_kill;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int         cyc;
    logic [5:0] rndx;
    logic       kill;
  } wb_exp_t;

  wb_exp_t sbq[$];

  stark_fpu_issue_arb #(
    .NREQ (NREQ),
    .LAT  (LAT),
    .RW   (RW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .iter      (iter),
    .rndx      (rndx),
    .stomp     (stomp),
    .gnt       (gnt),
    .fpu_issue (fpu_issue),
    .fpu_sel   (fpu_sel),
    .fpu_idle  (fpu_idle),
    .fpu_done  (fpu_done),
    .wb_v      (wb_v),
    .wb_rndx   (wb_rndx),
    .wb_kill   (wb_kill)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  // Drive one cycle's inputs just after the rising edge, return at the falling edge.
  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] it,
                               input logic [23:0] rn, input logic [63:0] st,
                               input logic done);
    @(posedge clk);
    #1;
    req      = r;
    iter     = it;
    rndx     = rn;
    stomp    = st;
    fpu_done = done;
    @(negedge clk);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(4'b0, 4'b0, 24'b0, 64'b0, 1'b0);
  endtask

  task automatic pushWb(input int c, input logic [5:0] r, input logic k);
    wb_exp_t e;
    e.cyc  = c;
    e.rndx = r;
    e.kill = k;
    sbq.push_back(e);
  endtask

  function automatic logic [23:0] rnd4(input logic [5:0] a0, input logic [5:0] a1,
                                       input logic [5:0] a2, input logic [5:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [63:0] sbit(input int i);
    logic [63:0] one;
    one = 64'd1;
    return one << i;
  endfunction

  // Writeback monitor: every wb_v must match the oldest expected entry.
  always @(negedge clk) begin
    wb_exp_t e;
    if (wb_v === 1'b1) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL wb_unexpected at cycle %0d: got rndx %0d kill %0b want none", cyc, wb_rndx, wb_kill);
      end else begin
        e = sbq.pop_front();
        checkOutput("wb_cycle", cyc, e.cyc);
        checkOutput("wb_rndx", {26'b0, wb_rndx}, {26'b0, e.rndx});
        checkOutput("wb_kill", {31'b0, wb_kill}, {31'b0, e.kill});
      end
    end else if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
      e = sbq.pop_front();
      total++;
      bad++;
      $display("[TB] FAIL wb_missing at cycle %0d: got no writeback want rndx %0d at cycle %0d", cyc, e.rndx, e.cyc);
    end
  end

  initial begin
    int g;
    int s;
    int exp_idx;
    logic [23:0] rv;

    rst      = 1'b1;
    req      = '0;
    iter     = '0;
    rndx     = '0;
    stomp    = '0;
    fpu_done = 1'b0;

    // Reset values.
    repeat (2) @(negedge clk);
    checkOutput("rst_issue", {31'b0, fpu_issue}, 0);
    checkOutput("rst_sel", {30'b0, fpu_sel}, 0);
    checkOutput("rst_wb_v", {31'b0, wb_v}, 0);
    checkOutput("rst_wb_rndx", {26'b0, wb_rndx}, 0);
    checkOutput("rst_wb_kill", {31'b0, wb_kill}, 0);
    checkOutput("rst_idle", {31'b0, fpu_idle}, 1);
    checkOutput("rst_gnt", {28'b0, gnt}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    // Round-robin fairness, all pipelined, back-to-back grants.
    rv = rnd4(6'd1, 6'd2, 6'd3, 6'd4);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(4'b1111, 4'b0000, rv, 64'b0, 1'b0);
`ifdef STARK_FPU_FIXED_PRIO_EN
      exp_idx = 0;
`else
      exp_idx = k % 4;
`endif
      checkOutput("rr_gnt", {28'b0, gnt}, 32'd1 << exp_idx);
      if (k > 0) begin
        checkOutput("rr_issue", {31'b0, fpu_issue}, 1);
`ifdef STARK_FPU_FIXED_PRIO_EN
        checkOutput("rr_sel", {30'b0, fpu_sel}, 0);
`else
        checkOutput("rr_sel", {30'b0, fpu_sel}, (k - 1) % 4);
`endif
      end
      pushWb(cyc + 1 + LAT, 6'(exp_idx + 1), 1'b0);
    end
    applyStimulus(4'b0, 4'b0, rv, 64'b0, 1'b0);
    checkOutput("rr_gnt_off", {28'b0, gnt}, 0);
    checkOutput("rr_last_issue", {31'b0, fpu_issue}, 1);
`ifdef STARK_FPU_FIXED_PRIO_EN
    checkOutput("rr_last_sel", {30'b0, fpu_sel}, 0);
`else
    checkOutput("rr_last_sel", {30'b0, fpu_sel}, 3);
`endif
    idleCycles(3);
    checkOutput("rr_drained_idle", {31'b0, fpu_idle}, 1);

    // Iterative serialisation behind a pipelined op.
    rv = rnd4(6'd10, 6'd20, 6'd0, 6'd0);
    applyStimulus(4'b0011, 4'b0010, rv, 64'b0, 1'b0);
    g = cyc;
    checkOutput("it_gnt_pipe", {28'b0, gnt}, 32'b0001);
    pushWb(g + 3, 6'd10, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(4'b0010, 4'b0010, rv, 64'b0, 1'b0);
      checkOutput("it_gnt_wait", {28'b0, gnt}, 0);
    end
    applyStimulus(4'b0010, 4'b0010, rv, 64'b0, 1'b0);
    checkOutput("it_gnt_iter", {28'b0, gnt}, 32'b0010);
    pushWb(g + 22, 6'd20, 1'b0);
    rv = rnd4(6'd11, 6'd20, 6'd0, 6'd0);
    for (int c = 5; c <= 21; c++) begin
      applyStimulus(4'b0001, 4'b0000, rv, 64'b0, (c == 21));
      checkOutput("it_busy_gnt", {28'b0, gnt}, 0);
      checkOutput("it_busy_idle", {31'b0, fpu_idle}, 0);
      if (c == 5) begin
        checkOutput("it_issue", {31'b0, fpu_issue}, 1);
        checkOutput("it_sel", {30'b0, fpu_sel}, 1);
      end
    end
    applyStimulus(4'b0001, 4'b0000, rv, 64'b0, 1'b0);
    checkOutput("it_wb_gnt", {28'b0, gnt}, 0);
    applyStimulus(4'b0001, 4'b0000, rv, 64'b0, 1'b0);
    checkOutput("it_resume_gnt", {28'b0, gnt}, 32'b0001);
    pushWb(cyc + 3, 6'd11, 1'b0);
    applyStimulus(4'b0, 4'b0, 24'b0, 64'b0, 1'b1);
    checkOutput("it_stray_done_gnt", {28'b0, gnt}, 0);
    idleCycles(4);
    checkOutput("it_drained_idle", {31'b0, fpu_idle}, 1);

    // Stomp one cycle after issue: sticky kill.
    applyStimulus(4'b0100, 4'b0, rnd4(6'd0, 6'd0, 6'd5, 6'd0), 64'b0, 1'b0);
    s = cyc;
    checkOutput("st_gnt", {28'b0, gnt}, 32'b0100);
    pushWb(s + 3, 6'd5, 1'b1);
    applyStimulus(4'b0, 4'b0, 24'b0, 64'b0, 1'b0);
    checkOutput("st_issue", {31'b0, fpu_issue}, 1);
    checkOutput("st_sel", {30'b0, fpu_sel}, 2);
    applyStimulus(4'b0, 4'b0, 24'b0, sbit(5), 1'b0);
    applyStimulus(4'b0, 4'b0, 24'b0, 64'b0, 1'b0);

    // Stomp on the writeback cycle itself; an unrelated stomp earlier.
    applyStimulus(4'b1000, 4'b0, rnd4(6'd0, 6'd0, 6'd0, 6'd7), 64'b0, 1'b0);
    checkOutput("stwb_gnt", {28'b0, gnt}, 32'b1000);
    pushWb(cyc + 3, 6'd7, 1'b1);
    applyStimulus(4'b0, 4'b0, 24'b0, sbit(8), 1'b0);
    applyStimulus(4'b0, 4'b0, 24'b0, 64'b0, 1'b0);
    applyStimulus(4'b0, 4'b0, 24'b0, sbit(7), 1'b0);
    idleCycles(1);

    // Stomp at request time: stomped requester is skipped.
    rv = rnd4(6'd12, 6'd0, 6'd9, 6'd0);
    applyStimulus(4'b0101, 4'b0, rv, sbit(9), 1'b0);
    checkOutput("sr_gnt_skip", {28'b0, gnt}, 32'b0001);
    pushWb(cyc + 3, 6'd12, 1'b0);
    applyStimulus(4'b0100, 4'b0, rv, 64'b0, 1'b0);
    checkOutput("sr_gnt_after", {28'b0, gnt}, 32'b0100);
    pushWb(cyc + 3, 6'd9, 1'b0);
    idleCycles(4);

    // Reset while BUSY, then a stray fpu_done.
    applyStimulus(4'b0010, 4'b0010, rnd4(6'd0, 6'd30, 6'd0, 6'd0), 64'b0, 1'b0);
    checkOutput("rb_gnt_iter", {28'b0, gnt}, 32'b0010);
    applyStimulus(4'b0, 4'b0, 24'b0, 64'b0, 1'b0);
    checkOutput("rb_busy_idle", {31'b0, fpu_idle}, 0);
    rv = rnd4(6'd33, 6'd0, 6'd0, 6'd0);
    @(posedge clk);
    #1;
    rst  = 1'b1;
    req  = 4'b0001;
    rndx = rv;
    @(negedge clk);
    checkOutput("rb_busy_gnt", {28'b0, gnt}, 0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    fpu_done = 1'b1;
    @(negedge clk);
    checkOutput("rb_after_idle", {31'b0, fpu_idle}, 1);
    checkOutput("rb_after_gnt", {28'b0, gnt}, 32'b0001);
    pushWb(cyc + 3, 6'd33, 1'b0);
    applyStimulus(4'b0, 4'b0, 24'b0, 64'b0, 1'b0);
    checkOutput("rb_no_wb", {31'b0, wb_v}, 0);
    checkOutput("rb_issue", {31'b0, fpu_issue}, 1);
    checkOutput("rb_sel", {30'b0, fpu_sel}, 0);
    idleCycles(4);

    // Two requesters, 4'b1010, repeatedly.
    rv = rnd4(6'd0, 6'd40, 6'd0, 6'd41);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(4'b1010, 4'b0, rv, 64'b0, 1'b0);
`ifdef STARK_FPU_FIXED_PRIO_EN
      exp_idx = 1;
`else
      exp_idx = (k % 2 == 0) ? 1 : 3;
`endif
      checkOutput("p2_gnt", {28'b0, gnt}, 32'd1 << exp_idx);
      pushWb(cyc + 3, (exp_idx == 1) ? 6'd40 : 6'd41, 1'b0);
    end
    idleCycles(5);
    checkOutput("end_idle", {31'b0, fpu_idle}, 1);
    checkOutput("end_sb_empty", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
